ddr2_wr_arb: RTL and testbench

- Round-robin arbiter sharing the single ddr2_wr write port (addr_i/data_i/stb_i/ack_o) among NUM_REQ write requesters, e.g. capture path, CPU bridge and test pattern generator.
- Each requester sees its own stb/ack word handshake.
- The arbiter registers the winning requester's address and data and drives one word at a time into ddr2_wr.
- It sits between the requesters and ddr2_wr in the clk_in domain.

---
 rtl/ddr2_wr_arb.sv | 200 ++++++++++++++++++++
 tb/tb_ddr2_wr_arb.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr2_wr_arb.sv
// Round-robin arbiter sharing one ddr2_wr write port among NUM_REQ requesters.
// Latency: 1 cycle from req_stb_i in IDLE to stb_o; 2 idle cycles (RESP+IDLE) between words.
// Backpressure: a word is held on stb_o/addr_o/data_o until ack_i rises; requesters wait on req_ack_o.
//
// Ports:
//   clk_in, rst        clock and asynchronous active-low reset
//   req_stb_i          per-requester level request, held until its req_ack_o pulse
//   req_addr_i/data_i  flattened per-requester word, requester i at [i*AW +: AW] / [i*DW +: DW]
//   req_ack_o          one-cycle pulse when the granted requester's word was accepted
//   grant_o            one-hot current owner, zero when idle
//   busy_o             high while a word is in flight or being acknowledged
//   stb_o/addr_o/data_o/ack_i  write port towards ddr2_wr
//
// Optional: define ARB_BURST_EN to let the current owner keep the grant for up
// to MAX_BURST consecutive words before round-robin resumes.
module ddr2_wr_arb #(
    parameter int NUM_REQ   = 3,
    parameter int AW        = 27,
    parameter int DW        = 128,
    parameter int MAX_BURST = 4
) (
    input  logic                  clk_in,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_stb_i,
    input  logic [NUM_REQ*AW-1:0] req_addr_i,
    input  logic [NUM_REQ*DW-1:0] req_data_i,
    output logic [NUM_REQ-1:0]    req_ack_o,
    output logic [NUM_REQ-1:0]    grant_o,
    output logic                  busy_o,
    output logic                  stb_o,
    output logic [AW-1:0]         addr_o,
    output logic [DW-1:0]         data_o,
    input  logic                  ack_i
);

    localparam int GW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 4 || MAX_BURST < 1) begin : g_param_chk
        $error("ddr2_wr_arb: NUM_REQ must be 2..4 and MAX_BURST at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic [GW-1:0]       last_grant;
    logic [GW-1:0]       rr_idx;
    logic                rr_found;
    logic [GW-1:0]       win_idx;
    logic [NUM_REQ-1:0]  win_oh;
    logic [AW-1:0]       sel_addr;
    logic [DW-1:0]       sel_data;
    logic                do_grant;
    logic                do_ack;
    logic                ack_q;
    logic                ack_rise;
    int                  rr_pos;
    logic [GW-1:0]       rr_cand;

`ifdef ARB_BURST_EN
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

    logic [BW-1:0]       burst_cnt;
    logic                own_vld;
    logic                keep_owner;
`endif

    // A word completes only on the rising edge of ack_i, so both a pulse and a
    // level ack from ddr2_wr retire exactly one word.
    assign ack_rise = ack_i & ~ack_q;
    assign busy_o   = (state != S_IDLE);

    // Round-robin search starting one past the last owner, wrapping modulo NUM_REQ.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = last_grant;
        rr_pos   = 0;
        rr_cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            rr_pos = int'(last_grant) + k;
            if (rr_pos >= NUM_REQ) begin
                rr_pos = rr_pos - NUM_REQ;
            end
            rr_cand = GW'(rr_pos);
            if (!rr_found && req_stb_i[rr_cand]) begin
                rr_found = 1'b1;
                rr_idx   = rr_cand;
            end
        end
    end

    // Winner selection and next-state logic.
    always_comb begin
        state_nxt = state;
        do_grant  = 1'b0;
        do_ack    = 1'b0;
`ifdef ARB_BURST_EN
        // own_vld keeps the reset value of last_grant from being mistaken for a live owner.
        keep_owner = own_vld && req_stb_i[last_grant] && (burst_cnt < BURST_LAST);
        win_idx    = keep_owner ? last_grant : rr_idx;
`else
        win_idx    = rr_idx;
`endif
        case (state)
            S_IDLE: begin
                if (rr_found) begin
                    do_grant  = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (ack_rise) begin
                    do_ack    = 1'b1;
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Mux the winner's word and build its one-hot grant.
    always_comb begin
        win_oh   = '0;
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == GW'(i)) begin
                win_oh[i] = 1'b1;
                sel_addr  = req_addr_i[i*AW +: AW];
                sel_data  = req_data_i[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Output and pointer registers. Reset abandons any in-flight word without acking it.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            ack_q      <= 1'b0;
            req_ack_o  <= '0;
            grant_o    <= '0;
            stb_o      <= 1'b0;
            addr_o     <= '0;
            data_o     <= '0;
            last_grant <= GW'(NUM_REQ - 1);
        end else begin
            ack_q     <= ack_i;
            req_ack_o <= do_ack ? grant_o : '0;
            if (do_grant) begin
                addr_o     <= sel_addr;
                data_o     <= sel_data;
                grant_o    <= win_oh;
                last_grant <= win_idx;
                stb_o      <= 1'b1;
            end
            if (do_ack) begin
                stb_o <= 1'b0;
            end
            if (state == S_RESP) begin
                grant_o <= '0;
            end
        end
    end

`ifdef ARB_BURST_EN
    // burst_cnt counts re-grants of the same owner; a fresh grant restarts it and an
    // owner that drops its request forfeits the burst.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            burst_cnt <= '0;
            own_vld   <= 1'b0;
        end else if (do_grant) begin
            own_vld   <= 1'b1;
            burst_cnt <= keep_owner ? burst_cnt + 1'b1 : '0;
        end else if (state == S_IDLE && own_vld && !req_stb_i[last_grant]) begin
            own_vld   <= 1'b0;
            burst_cnt <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_ddr2_wr_arb.sv
// Self-checking bench for ddr2_wr_arb: requester drivers, a ddr2_wr ack model,
// and a monitor that pops expected words/acks from scoreboard queues.
module tb_ddr2_wr_arb;

    localparam int NR = 3;
    localparam int AW = 27;
    localparam int DW = 128;

    logic              clk_in = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_stb_i;
    logic [NR*AW-1:0]  req_addr_i;
    logic [NR*DW-1:0]  req_data_i;
    logic [NR-1:0]     req_ack_o;
    logic [NR-1:0]     grant_o;
    logic              busy_o;
    logic              stb_o;
    logic [AW-1:0]     addr_o;
    logic [DW-1:0]     data_o;
    logic              ack_i;

    always #5 clk_in = ~clk_in;

    ddr2_wr_arb #(.NUM_REQ(NR), .AW(AW), .DW(DW), .MAX_BURST(4)) dut (
        .clk_in     (clk_in),
        .rst        (rst_n),
        .req_stb_i  (req_stb_i),
        .req_addr_i (req_addr_i),
        .req_data_i (req_data_i),
        .req_ack_o  (req_ack_o),
        .grant_o    (grant_o),
        .busy_o     (busy_o),
        .stb_o      (stb_o),
        .addr_o     (addr_o),
        .data_o     (data_o),
        .ack_i      (ack_i)
    );

    typedef struct {
        int            idx;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t exp_word_q[$];
    int   exp_ack_q[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int ack_cnt [NR];

    logic [AW-1:0] tab_addr [NR][8];
    logic [DW-1:0] tab_data [NR][8];
    int            n_words  [NR];
    int            ptr      [NR];
    int            rise_cyc [NR];

    bit ack_en   = 1'b1;
    int ack_lat  = 20;
    int ack_hold = 1;

    function automatic logic [NR-1:0] oh(input int i);
        logic [NR-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [DW-1:0] mk_data(input int t, input int i, input int w);
        logic [31:0] a, b, c, d;
        a = 32'hD000_0000 + 32'(t);
        b = 32'h0000_1000 + 32'(i);
        c = 32'h0000_2000 + 32'(w);
        d = ~(a ^ b ^ c);
        return {a, b, c, d};
    endfunction

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic load_req(input int i, input int n, input logic [AW-1:0] base, input int t);
        for (int w = 0; w < n; w++) begin
            tab_addr[i][w] = base + AW'(w * 'h100);
            tab_data[i][w] = mk_data(t, i, w);
        end
        ptr[i]     = 0;
        n_words[i] = n;
    endtask

    task automatic push_word(input int i, input int w, input bit with_ack);
        exp_t e;
        e.idx  = i;
        e.addr = tab_addr[i][w];
        e.data = tab_data[i][w];
        exp_word_q.push_back(e);
        if (with_ack) exp_ack_q.push_back(i);
    endtask

    function automatic int ack_total();
        int s = 0;
        for (int i = 0; i < NR; i++) s += ack_cnt[i];
        return s;
    endfunction

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while ((exp_word_q.size() != 0 || exp_ack_q.size() != 0 || busy_o !== 1'b0) && n < budget) begin
            @(negedge clk_in);
            n++;
        end
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL %s timeout after %0d cycles words_left=%0d acks_left=%0d",
                     name, n, exp_word_q.size(), exp_ack_q.size());
        end
        repeat (4) @(negedge clk_in);
    endtask

    task automatic wait_stb(input string name);
        int n = 0;
        while (stb_o !== 1'b1 && n < 50) begin
            @(negedge clk_in);
            n++;
        end
        checks++;
        if (n >= 50) begin
            failures++;
            $display("FAIL %s stb_o never rose got=%b expected=1", name, stb_o);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst_n = 1'b0;
        for (int i = 0; i < NR; i++) n_words[i] = 0;
        repeat (2) @(negedge clk_in);
        rst_n = 1'b1;
        @(negedge clk_in);
    endtask

    initial forever begin
        @(posedge clk_in);
        cyc++;
    end

    // Requester drivers: advance to the next word after the ack pulse, update
    // just after the edge that ends the RESP cycle.
    initial begin
        logic [NR-1:0] acked;
        req_stb_i  = '0;
        req_addr_i = '0;
        req_data_i = '0;
        forever begin
            @(negedge clk_in);
            acked = req_ack_o;
            @(posedge clk_in);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (acked[i] && ptr[i] < n_words[i]) ptr[i]++;
                if (ptr[i] < n_words[i]) begin
                    if (!req_stb_i[i]) rise_cyc[i] = cyc;
                    req_stb_i[i]              = 1'b1;
                    req_addr_i[i*AW +: AW]    = tab_addr[i][ptr[i]];
                    req_data_i[i*DW +: DW]    = tab_data[i][ptr[i]];
                end else begin
                    req_stb_i[i] = 1'b0;
                end
            end
        end
    end

    // ddr2_wr model: raise ack ack_lat cycles after stb_o, hold it ack_hold cycles.
    initial begin
        bit in_word;
        int acnt;
        ack_i   = 1'b0;
        in_word = 1'b0;
        acnt    = 0;
        forever begin
            @(posedge clk_in);
            #1;
            if (!rst_n) begin
                in_word = 1'b0;
                ack_i   = 1'b0;
            end else begin
                if (stb_o && !in_word && ack_en) begin
                    in_word = 1'b1;
                    acnt    = 0;
                end
                if (in_word) begin
                    acnt++;
                    if (acnt == ack_lat) ack_i = 1'b1;
                    if (acnt == ack_lat + ack_hold) begin
                        ack_i   = 1'b0;
                        in_word = 1'b0;
                    end
                end
            end
        end
    end

    // Monitor: compares every issued word and every ack pulse against the queues.
    initial begin
        exp_t          e;
        int            ai;
        bit            stb_prev;
        bit            ack_prev;
        bit            had_word;
        int            gap;
        logic [NR-1:0] h_grant;
        logic [AW-1:0] h_addr;
        logic [DW-1:0] h_data;
        stb_prev = 1'b0;
        ack_prev = 1'b0;
        had_word = 1'b0;
        gap      = 0;
        h_grant  = '0;
        h_addr   = '0;
        h_data   = '0;
        for (int i = 0; i < NR; i++) ack_cnt[i] = 0;
        forever begin
            @(negedge clk_in);
            if (!rst_n) begin
                stb_prev = 1'b0;
                ack_prev = 1'b0;
                had_word = 1'b0;
                gap      = 0;
            end else begin
                if (stb_o && !stb_prev) begin
                    if (had_word) begin
                        checks++;
                        if (gap < 2) begin
                            failures++;
                            $display("FAIL stb_gap got=%0d expected>=2", gap);
                        end
                    end
                    had_word = 1'b1;
                    if (exp_word_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_word grant=%b addr=%0h expected=none", grant_o, addr_o);
                    end else begin
                        e = exp_word_q.pop_front();
                        chk("word_grant", grant_o, oh(e.idx));
                        chk("word_addr", addr_o, e.addr);
                        chk("word_data", data_o, e.data);
                        chk("word_busy", busy_o, 1'b1);
                    end
                    h_grant = grant_o;
                    h_addr  = addr_o;
                    h_data  = data_o;
                end else if (stb_o) begin
                    chk("hold_grant", grant_o, h_grant);
                    chk("hold_addr", addr_o, h_addr);
                    chk("hold_data", data_o, h_data);
                end
                gap = stb_o ? 0 : gap + 1;

                if (req_ack_o != '0) begin
                    chk("ack_width", ack_prev, 1'b0);
                    for (int i = 0; i < NR; i++) if (req_ack_o[i]) ack_cnt[i]++;
                    if (exp_ack_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_ack got=%b expected=none", req_ack_o);
                    end else begin
                        ai = exp_ack_q.pop_front();
                        chk("ack_req", req_ack_o, oh(ai));
                        chk("ack_grant", grant_o, oh(ai));
                    end
                end
                ack_prev = (req_ack_o != '0);
                stb_prev = stb_o;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int base_ack[NR];
        int n;
        int cnt;
        int seq[12];
        int wc[2];
        for (int i = 0; i < NR; i++) begin
            n_words[i]  = 0;
            ptr[i]      = 0;
            rise_cyc[i] = 0;
        end
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        repeat (3) @(negedge clk_in);
        chk("rst_stb", stb_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_ack", req_ack_o, '0);
        chk("rst_grant", grant_o, '0);
        chk("rst_addr", addr_o, '0);
        chk("rst_data", data_o, '0);
        rst_n = 1'b1;
        @(negedge clk_in);

        // Single requester, 20-cycle ack.
        tab_addr[0][0] = '0;
        tab_data[0][0] = 128'hF7D5FC30_0703F45B_FFB3E735_F61802C6;
        ptr[0]     = 0;
        n_words[0] = 1;
        push_word(0, 0, 1'b1);
        wait_stb("t1");
        chk("issue_latency", 128'(cyc - rise_cyc[0]), 128'd1);
        wait_done("t1", 200);
        chk("t1_acks", ack_cnt[0], 1);

        // ack_i rising while idle must not complete anything.
        n = ack_total();
        ack_i = 1'b1;
        @(negedge clk_in);
        ack_i = 1'b0;
        repeat (3) @(negedge clk_in);
        chk("idle_ack_ignored", ack_total(), n);
        chk("idle_ack_stb", stb_o, 1'b0);

        // All three requesters, two words each.
        do_reset();
        ack_lat = 4;
        for (int i = 0; i < NR; i++) base_ack[i] = ack_cnt[i];
        for (int i = 0; i < NR; i++) load_req(i, 2, AW'(8 * (i + 1)), 2);
`ifdef ARB_BURST_EN
        for (int i = 0; i < NR; i++) for (int w = 0; w < 2; w++) push_word(i, w, 1'b1);
`else
        for (int w = 0; w < 2; w++) for (int i = 0; i < NR; i++) push_word(i, w, 1'b1);
`endif
        wait_done("t2", 500);
        for (int i = 0; i < NR; i++) chk("t2_acks", ack_cnt[i] - base_ack[i], 2);

        // Requesters 1 and 2 together after last grant went to 1.
        do_reset();
        load_req(1, 1, 'h200, 3);
        push_word(1, 0, 1'b1);
        wait_done("t3a", 200);
        load_req(1, 1, 'h300, 3);
        load_req(2, 1, 'h400, 3);
        push_word(2, 0, 1'b1);
        push_word(1, 0, 1'b1);
        wait_done("t3b", 300);

        // Reset while ISSUE waits for an ack that never comes.
        do_reset();
        ack_en = 1'b0;
        load_req(1, 1, 'h500, 4);
        push_word(1, 0, 1'b0);
        wait_stb("t4");
        repeat (3) @(negedge clk_in);
        n = ack_total();
        rst_n = 1'b0;
        for (int i = 0; i < NR; i++) n_words[i] = 0;
        #1;
        chk("arst_stb", stb_o, 1'b0);
        chk("arst_grant", grant_o, '0);
        chk("arst_busy", busy_o, 1'b0);
        repeat (2) @(negedge clk_in);
        chk("arst_no_ack", ack_total(), n);
        rst_n  = 1'b1;
        ack_en = 1'b1;
        @(negedge clk_in);
        for (int i = 0; i < NR; i++) load_req(i, 1, AW'('h600 + 'h10 * i), 4);
        for (int i = 0; i < NR; i++) push_word(i, 0, 1'b1);
        wait_done("t4", 300);

        // Level ack held for 10 cycles.
        do_reset();
        ack_lat  = 3;
        ack_hold = 10;
        load_req(0, 2, 'h700, 5);
        push_word(0, 0, 1'b1);
        push_word(0, 1, 1'b1);
        n = 0;
        while (ack_i !== 1'b1 && n < 100) begin
            @(negedge clk_in);
            n++;
        end
        cnt = 0;
        for (int k = 0; k < 11; k++) begin
            if (req_ack_o != '0) cnt++;
            @(negedge clk_in);
        end
        chk("level_ack_single", cnt, 1);
        wait_done("t5", 300);
        ack_hold = 1;

        // Two continuous requesters: alternation, or bursts of four.
        do_reset();
        ack_lat = 2;
        load_req(0, 6, 'h1000, 6);
        load_req(1, 6, 'h2000, 6);
`ifdef ARB_BURST_EN
        seq = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1};
`else
        seq = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`endif
        wc[0] = 0;
        wc[1] = 0;
        for (int k = 0; k < 12; k++) begin
            push_word(seq[k], wc[seq[k]], 1'b1);
            wc[seq[k]]++;
        end
        wait_done("t6", 800);

        chk("word_q_empty", exp_word_q.size(), 0);
        chk("ack_q_empty", exp_ack_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
